// File: rtl/div_pkg.sv
// Shared widths, divider latency and the tag record that rides alongside each
// divide through the latency-matched shift pipeline.
package div_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int NUMERATOR_W   = 72;
    localparam int DENOMINATOR_W = 8;
    localparam int QUOTIENT_W    = 64;
    localparam int DIV_LAT       = 72;

    // Requester ids wider than this cannot be carried in the tag.
    localparam int TAG_ID_W = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                den_is_zero;
    } tag_t;

endpackage

// File: rtl/div_arbiter_rr.sv
// One-hot round-robin grant: first requester after the last winner, cyclically.
// The pointer advances only when a grant is actually issued.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               block_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_vld_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        // Walk from farthest to nearest so the nearest valid index wins last.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = ID_W'((int'(ptr_q) + off) % NUM_REQ);
            if (req_i[idx] && !block_i) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                gnt_vld_o  = 1'b1;
            end
        end
        ptr_d = gnt_vld_o ? gnt_id_o : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= ID_W'(NUM_REQ - 1);
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external fixed-latency divider among NUM_REQ requesters; a tag
// pipeline matched to the divider latency routes each quotient back in order.
module div_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ           = NUM_REQ_DEF,
    parameter int NUMERATOR_WIDTH   = NUMERATOR_W,
    parameter int DENOMINATOR_WIDTH = DENOMINATOR_W,
    parameter int QUOTIENT_WIDTH    = QUOTIENT_W,
    parameter int DIV_LATENCY       = DIV_LAT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUMERATOR_WIDTH-1:0]     req_numerator,
    input  logic [NUM_REQ*DENOMINATOR_WIDTH-1:0]   req_denominator,
    input  logic                                   hold,
    output logic                                   rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
    output logic [QUOTIENT_WIDTH-1:0]              rsp_quotient,
    output logic                                   rsp_div_by_zero,
    output logic                                   div_valid_in,
    output logic [NUMERATOR_WIDTH-1:0]             div_numerator,
    output logic [DENOMINATOR_WIDTH-1:0]           div_denominator,
    input  logic                                   div_valid_out,
    input  logic [QUOTIENT_WIDTH-1:0]              div_quotient,
    output logic [$clog2(DIV_LATENCY+2)-1:0]       inflight_count,
    output logic                                   err_orphan
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DIV_LATENCY + 2);

    logic [ID_W-1:0]              gnt_id;
    logic                         gnt_vld;
    logic [NUMERATOR_WIDTH-1:0]   num_sel;
    logic [DENOMINATOR_WIDTH-1:0] den_sel;

    logic                         dvi_q, dvi_d;
    logic [NUMERATOR_WIDTH-1:0]   num_q, num_d;
    logic [DENOMINATOR_WIDTH-1:0] den_q, den_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         orphan_q, orphan_d;
    tag_t                         tag_in, tag_out;
    tag_t                         tag_q [DIV_LATENCY+1];

    // Reset also blocks grants so nothing is accepted while state is clearing.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid),
        .block_i  (hold | rst),
        .gnt_o    (req_ready),
        .gnt_id_o (gnt_id),
        .gnt_vld_o(gnt_vld)
    );

    assign num_sel = req_numerator[gnt_id*NUMERATOR_WIDTH +: NUMERATOR_WIDTH];
    assign den_sel = req_denominator[gnt_id*DENOMINATOR_WIDTH +: DENOMINATOR_WIDTH];
    assign tag_out = tag_q[DIV_LATENCY];

    assign rsp_valid       = div_valid_out & tag_out.valid & ~rst;
    assign rsp_id          = ID_W'(tag_out.id);
    assign rsp_quotient    = div_quotient;
    assign rsp_div_by_zero = rsp_valid & tag_out.den_is_zero;

    always_comb begin
        dvi_d              = gnt_vld;
        num_d              = gnt_vld ? num_sel : num_q;
        den_d              = gnt_vld ? den_sel : den_q;
        tag_in.valid       = gnt_vld;
        tag_in.id          = TAG_ID_W'(gnt_id);
        tag_in.den_is_zero = (den_sel == '0);
        cnt_d              = cnt_q;
        unique case ({gnt_vld, rsp_valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // Divider and tag pipeline must agree every cycle; any skew is sticky.
        orphan_d = orphan_q | (div_valid_out ^ tag_out.valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvi_q    <= 1'b0;
            num_q    <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
            for (int k = 0; k <= DIV_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            dvi_q    <= dvi_d;
            num_q    <= num_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
            tag_q[0] <= tag_in;
            for (int k = 1; k <= DIV_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign div_valid_in    = dvi_q;
    assign div_numerator   = num_q;
    assign div_denominator = den_q;
    assign inflight_count  = cnt_q;
    assign err_orphan      = orphan_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, round-robin/scoreboard monitor,
// table-driven single requests and hand-written multi-cycle sequences.
module tb_div_arbiter;
    import div_pkg::*;

    localparam int N  = 4;
    localparam int NW = 72;
    localparam int DW = 8;
    localparam int QW = 64;
    localparam int L  = 72;
    localparam int CW = $clog2(L + 2);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*NW-1:0] req_numerator;
    logic [N*DW-1:0] req_denominator;
    logic            hold;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [QW-1:0]   rsp_quotient;
    logic            rsp_div_by_zero;
    logic            div_valid_in;
    logic [NW-1:0]   div_numerator;
    logic [DW-1:0]   div_denominator;
    logic            div_valid_out;
    logic [QW-1:0]   div_quotient;
    logic [CW-1:0]   inflight_count;
    logic            err_orphan;
    logic            force_dvo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_numerator(req_numerator), .req_denominator(req_denominator),
        .hold(hold), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_div_by_zero(rsp_div_by_zero),
        .div_valid_in(div_valid_in), .div_numerator(div_numerator),
        .div_denominator(div_denominator), .div_valid_out(div_valid_out),
        .div_quotient(div_quotient), .inflight_count(inflight_count),
        .err_orphan(err_orphan)
    );

    function automatic logic [QW-1:0] divq(input logic [NW-1:0] n, input logic [DW-1:0] d);
        if (d == '0) return '1;
        return QW'(n / NW'(d));
    endfunction

    // Behavioural divider: fixed latency L from div_valid_in, shares rst.
    typedef struct packed { logic v; logic [QW-1:0] q; } dstage_t;
    dstage_t dpipe [L];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) dpipe[k] <= '0;
        end else begin
            dpipe[0] <= {div_valid_in, divq(div_numerator, div_denominator)};
            for (int k = 1; k < L; k++) dpipe[k] <= dpipe[k-1];
        end
    end
    assign div_valid_out = dpipe[L-1].v | force_dvo;
    assign div_quotient  = dpipe[L-1].q;

    task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: entries pushed when the bench's own arbiter model predicts a
    // handshake, popped when the DUT raises rsp_valid.
    typedef struct {
        int            id;
        logic [QW-1:0] q;
        logic          dbz;
        int            due;
    } sb_t;
    sb_t sbq[$];
    int  ptr_m = N - 1;

    always @(negedge clk) begin : mon
        logic [N-1:0] eg;
        int           gid;
        sb_t          e;
        eg  = '0;
        gid = -1;
        if (rst) begin
            chk("rst_req_ready", NW'(req_ready), '0);
            chk("rst_rsp_valid", NW'(rsp_valid), '0);
            sbq.delete();
            ptr_m = N - 1;
        end else begin
            chk("inflight_count", NW'(inflight_count), NW'(sbq.size()));
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected none", rsp_id);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_id", NW'(rsp_id), NW'(e.id));
                    chk("sb_quotient", NW'(rsp_quotient), NW'(e.q));
                    chk("sb_dbz", NW'(rsp_div_by_zero), NW'(e.dbz));
                    chk("sb_cycle", NW'(cyc), NW'(e.due));
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                total++; bad++;
                $display("FAIL rsp_missing: got no rsp_valid expected id=%0d at cycle %0d", sbq[0].id, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (!hold)
                for (int off = N; off >= 1; off--)
                    if (req_valid[(ptr_m + off) % N]) gid = (ptr_m + off) % N;
            if (gid >= 0) eg[gid] = 1'b1;
            chk("grant", NW'(req_ready), NW'(eg));
            if (gid >= 0) begin
                sbq.push_back('{gid,
                                divq(req_numerator[gid*NW +: NW], req_denominator[gid*DW +: DW]),
                                (req_denominator[gid*DW +: DW] == '0),
                                cyc + 1 + L});
                ptr_m = gid;
            end
        end
    end

    task automatic send_one(input int id, input logic [NW-1:0] n, input logic [DW-1:0] d,
                            output int hs);
        req_numerator[id*NW +: NW]   = n;
        req_denominator[id*DW +: DW] = d;
        req_valid[id]                = 1'b1;
        hs = -1;
        for (int k = 0; k < 50 && hs < 0; k++) begin
            @(negedge clk);
            if (req_ready[id]) hs = cyc;
        end
        if (hs < 0) begin
            total++; bad++;
            $display("FAIL hs_timeout: got no req_ready[%0d] expected handshake", id);
        end
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int hs, output int lat);
        lat = -1;
        for (int k = 0; k < 120 && lat < 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = cyc - hs;
        end
    endtask

    typedef struct {
        int            id;
        logic [NW-1:0] n;
        logic [DW-1:0] d;
        logic [QW-1:0] q;
        logic          dbz;
    } vec_t;
    vec_t tv[7];

    initial begin : stim
        int hs, lat, first_hs, nrsp;
        int rid[5];
        int rcy[5];

        tv[0] = '{2, 72'd1000, 8'd7, 64'd142, 1'b0};
        tv[1] = '{1, 72'd555, 8'd0, {QW{1'b1}}, 1'b1};
        tv[2] = '{0, 72'd12345, 8'd1, 64'd12345, 1'b0};
        tv[3] = '{3, 72'h1_0000_0000_0000_0000, 8'd2, 64'h8000_0000_0000_0000, 1'b0};
        tv[4] = '{1, {NW{1'b1}}, 8'd1, {QW{1'b1}}, 1'b0};
        tv[5] = '{2, 72'd5, 8'd9, 64'd0, 1'b0};
        tv[6] = '{3, 72'd65535, 8'd255, 64'd257, 1'b0};

        rst = 1'b1; hold = 1'b0; force_dvo = 1'b0;
        req_valid = '0; req_numerator = '0; req_denominator = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_div_valid_in", NW'(div_valid_in), '0);
        chk("reset_div_numerator", div_numerator, '0);
        chk("reset_div_denominator", NW'(div_denominator), '0);
        chk("reset_inflight", NW'(inflight_count), '0);
        chk("reset_err_orphan", NW'(err_orphan), '0);
        tick();

        // Single requests from the table, one in flight at a time.
        foreach (tv[i]) begin
            send_one(tv[i].id, tv[i].n, tv[i].d, hs);
            @(negedge clk);
            chk("div_valid_in_pulse", NW'(div_valid_in), 1);
            chk("div_numerator", div_numerator, tv[i].n);
            chk("div_denominator", NW'(div_denominator), NW'(tv[i].d));
            @(negedge clk);
            chk("div_valid_in_one_cycle", NW'(div_valid_in), '0);
            chk("div_numerator_held", div_numerator, tv[i].n);
            wait_rsp(hs, lat);
            chk("tv_latency", NW'(lat), NW'(L + 1));
            chk("tv_rsp_id", NW'(rsp_id), NW'(tv[i].id));
            chk("tv_quotient", NW'(rsp_quotient), NW'(tv[i].q));
            chk("tv_dbz", NW'(rsp_div_by_zero), NW'(tv[i].dbz));
            tick();
        end

        // Hold: three ops in flight drain while grants are blocked.
        req_numerator = {72'd400, 72'd300, 72'd200, 72'd100};
        req_denominator = {8'd4, 8'd3, 8'd2, 8'd1};
        req_valid = 4'b0011;
        repeat (3) tick();
        req_valid = '0;
        repeat (58) tick();
        hold = 1'b1; req_valid = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("hold_no_grant", NW'(req_ready), '0);
        end
        chk("hold_drained", NW'(inflight_count), '0);
        tick();
        hold = 1'b0; req_valid = '0;
        tick();

        // Mid-flight reset discards five operations.
        req_valid = 4'b1111;
        repeat (5) tick();
        req_valid = '0;
        repeat (10) tick();
        @(negedge clk);
        chk("pre_reset_inflight", NW'(inflight_count), 5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_inflight", NW'(inflight_count), '0);
        nrsp = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("post_reset_no_rsp", NW'(nrsp), '0);
        tick();

        // All four continuously valid: grants 0,1,2,3,0 then ordered responses.
        req_numerator = {72'd9000, 72'd700, 72'd50, 72'd3};
        req_denominator = {8'd9, 8'd7, 8'd5, 8'd3};
        req_valid = 4'b1111;
        first_hs = -1;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            if (g == 0) first_hs = cyc;
            chk("rr_order", NW'(req_ready), NW'(1 << (g % 4)));
        end
        tick();
        req_valid = '0;
        nrsp = 0;
        for (int k = 0; k < 120 && nrsp < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rid[nrsp] = rsp_id;
                rcy[nrsp] = cyc;
                nrsp++;
            end
        end
        chk("rr_rsp_count", NW'(nrsp), 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_rsp_id", NW'(rid[k]), NW'(k % 4));
            chk("rr_rsp_cycle", NW'(rcy[k]), NW'(first_hs + L + 1 + k));
        end
        tick();

        // Orphan divider strobe: sticky error until reset.
        @(negedge clk);
        chk("orphan_clear_before", NW'(err_orphan), '0);
        tick();
        force_dvo = 1'b1;
        tick();
        force_dvo = 1'b0;
        @(negedge clk);
        chk("orphan_set", NW'(err_orphan), 1);
        repeat (10) tick();
        @(negedge clk);
        chk("orphan_sticky", NW'(err_orphan), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("orphan_cleared_by_rst", NW'(err_orphan), '0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
